el2_lsu_clken_gen: RTL and testbench

- Parametrised clock-enable generator for the LSU, successor to the fixed-width LSU clock-domain enable logic.
- Produces per-stage c1/c2/store enables for an NSTAGE-deep pipeline.
- Produces NCH auxiliary channel enables with programmable idle hysteresis and optional bus-clock qualification, plus a free-clock enable and an idle status.
- Outputs enables only; rvoclkhdr/rvclkhdr instances stay in the parent.

---
 rtl/el2_pkg.sv | 30 +++
 rtl/el2_lsu_clken_hyst.sv | 42 ++++
 rtl/el2_lsu_clken_gen.sv | 92 +++++++++
 tb/tb_el2_lsu_clken_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/el2_pkg.sv
// Shared LSU clock-enable definitions: channel indices,
// hysteresis counter width and default per-channel hold lengths.
package el2_pkg;

    typedef enum logic [1:0] {
        STBUF  = 2'd0,
        IBUF   = 2'd1,
        OBUF   = 2'd2,
        BUSBUF = 2'd3
    } el2_lsu_ch_e;

    localparam int LSU_CLKEN_HOLD_W = 4;

    localparam logic [LSU_CLKEN_HOLD_W-1:0] HOLD_STBUF  = LSU_CLKEN_HOLD_W'(2);
    localparam logic [LSU_CLKEN_HOLD_W-1:0] HOLD_IBUF   = LSU_CLKEN_HOLD_W'(1);
    localparam logic [LSU_CLKEN_HOLD_W-1:0] HOLD_OBUF   = LSU_CLKEN_HOLD_W'(1);
    localparam logic [LSU_CLKEN_HOLD_W-1:0] HOLD_BUSBUF = LSU_CLKEN_HOLD_W'(3);

    localparam logic [4*LSU_CLKEN_HOLD_W-1:0] HOLD_DEFAULT =
        {HOLD_BUSBUF, HOLD_OBUF, HOLD_IBUF, HOLD_STBUF};

    // Hold length of one channel out of a packed cfg_hold vector
    function automatic logic [LSU_CLKEN_HOLD_W-1:0] hold_of(
        input logic [4*LSU_CLKEN_HOLD_W-1:0] cfg,
        input el2_lsu_ch_e                   ch
    );
        return cfg[int'(ch)*LSU_CLKEN_HOLD_W +: LSU_CLKEN_HOLD_W];
    endfunction

endpackage

// File: rtl/el2_lsu_clken_hyst.sv
// One auxiliary channel: request hysteresis counter plus its
// clock enable, optionally qualified by the bus clock ratio.
module el2_lsu_clken_hyst
    import el2_pkg::*;
#(
    parameter int HOLD_W = LSU_CLKEN_HOLD_W,
    parameter bit BUS_Q  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              bus_clk_en,
    input  logic              clk_override,
    input  logic              scan_mode,
    input  logic [HOLD_W-1:0] hold,
    output logic              act,
    output logic              en
);

    logic [HOLD_W-1:0] cnt;
    logic              tick;

    // Bus-qualified channels only age on bus clock ticks
    assign tick = BUS_Q ? bus_clk_en : 1'b1;

    // Reload on request, otherwise count down to zero on ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (req) begin
            cnt <= hold;
        end else if ((cnt != '0) && tick) begin
            cnt <= cnt - HOLD_W'(1);
        end
    end

    assign act = req | (cnt != '0);

    // scan_mode bypasses the bus gate; clk_override does not
    assign en = scan_mode | ((act | clk_override) & tick);

endmodule

// File: rtl/el2_lsu_clken_gen.sv
// LSU clock-enable generator: per-stage c1/c2/store enables,
// per-channel hysteresis enables, free enable and idle status.
module el2_lsu_clken_gen
    import el2_pkg::*;
#(
    parameter int             NSTAGE   = 3,
    parameter int             NCH      = 4,
    parameter int             HOLD_W   = LSU_CLKEN_HOLD_W,
    parameter logic [NCH-1:0] BUS_MASK = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_override,
    input  logic                  scan_mode,
    input  logic [NSTAGE-1:0]     stage_vld,
    input  logic [NSTAGE-1:0]     stage_store,
    input  logic [NCH-1:0]        ch_req,
    input  logic                  ch_bus_clk_en,
    input  logic [NCH*HOLD_W-1:0] cfg_hold,
    input  logic                  free_busy,
    output logic [NSTAGE-1:0]     c1_en,
    output logic [NSTAGE-1:0]     c2_en,
    output logic [NSTAGE-1:0]     store_c1_en,
    output logic [NCH-1:0]        ch_en,
    output logic                  free_c2_en,
    output logic                  all_idle
);

    logic              ovr;
    logic [NSTAGE-1:0] c1_raw;
    logic [NSTAGE-1:0] c1_q;
    logic [NCH-1:0]    ch_act;
    logic              free_c1;
    logic              free_q;

    assign ovr = clk_override | scan_mode;

    // A packet walks the stage chain one stage per cycle
    assign c1_raw[0] = stage_vld[0];

    if (NSTAGE > 1) begin : g_chain
        assign c1_raw[NSTAGE-1:1] =
            stage_vld[NSTAGE-1:1] | c1_q[NSTAGE-2:0];
    end

    // Registered copy of the stage activity
    always_ff @(posedge clk) begin
        if (rst) begin
            c1_q <= '0;
        end else begin
            c1_q <= c1_raw;
        end
    end

    assign c1_en       = c1_raw | {NSTAGE{ovr}};
    assign c2_en       = c1_raw | c1_q | {NSTAGE{ovr}};
    assign store_c1_en = (c1_raw & stage_store) | {NSTAGE{ovr}};

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        el2_lsu_clken_hyst #(
            .HOLD_W (HOLD_W),
            .BUS_Q  (BUS_MASK[k])
        ) u_hyst (
            .clk          (clk),
            .rst          (rst),
            .req          (ch_req[k]),
            .bus_clk_en   (ch_bus_clk_en),
            .clk_override (clk_override),
            .scan_mode    (scan_mode),
            .hold         (cfg_hold[k*HOLD_W +: HOLD_W]),
            .act          (ch_act[k]),
            .en           (ch_en[k])
        );
    end

    assign free_c1 = (|stage_vld) | (|c1_q) | free_busy
                   | (|ch_act) | ovr;

    assign free_c2_en = free_c1 | free_q;

    // Free enable history and idle flag (idle once two quiet cycles seen)
    always_ff @(posedge clk) begin
        if (rst) begin
            free_q   <= 1'b0;
            all_idle <= 1'b1;
        end else begin
            free_q   <= free_c1;
            all_idle <= ~(free_c1 | free_q);
        end
    end

endmodule

// File: tb/tb_el2_lsu_clken_gen.sv
// Randomized self-checking bench for el2_lsu_clken_gen against
// a history-based reference model of the enable rules.
module tb_el2_lsu_clken_gen;
    import el2_pkg::*;

    localparam int             NS   = 3;
    localparam int             NC   = 4;
    localparam int             HW   = LSU_CLKEN_HOLD_W;
    localparam logic [NC-1:0]  MASK = 4'b0100;
    localparam int             NCYC = 3000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clk_override = 1'b0;
    logic             scan_mode = 1'b0;
    logic [NS-1:0]    stage_vld = '0;
    logic [NS-1:0]    stage_store = '0;
    logic [NC-1:0]    ch_req = '0;
    logic             ch_bus_clk_en = 1'b0;
    logic [NC*HW-1:0] cfg_hold = '0;
    logic             free_busy = 1'b0;
    logic [NS-1:0]    c1_en;
    logic [NS-1:0]    c2_en;
    logic [NS-1:0]    store_c1_en;
    logic [NC-1:0]    ch_en;
    logic             free_c2_en;
    logic             all_idle;

    el2_lsu_clken_gen #(
        .NSTAGE   (NS),
        .NCH      (NC),
        .HOLD_W   (HW),
        .BUS_MASK (MASK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_override  (clk_override),
        .scan_mode     (scan_mode),
        .stage_vld     (stage_vld),
        .stage_store   (stage_store),
        .ch_req        (ch_req),
        .ch_bus_clk_en (ch_bus_clk_en),
        .cfg_hold      (cfg_hold),
        .free_busy     (free_busy),
        .c1_en         (c1_en),
        .c2_en         (c2_en),
        .store_c1_en   (store_c1_en),
        .ch_en         (ch_en),
        .free_c2_en    (free_c2_en),
        .all_idle      (all_idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    // hist[d] = stage_vld as seen d cycles ago (d >= 1)
    logic [NS-1:0] hist [0:NS];
    int            rem [NC];
    logic          f_prev;
    logic          idle_m;

    // Stage activity s cycles ago: any packet that entered stage j
    // exactly (i - j) cycles before keeps stage i busy now
    function automatic logic [NS-1:0] c1_at(input int s);
        logic [NS-1:0] r;
        r = '0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j <= i; j++) begin
                int d;
                d = i - j + s;
                if (d == 0) r[i] = r[i] | stage_vld[j];
                else        r[i] = r[i] | hist[d][j];
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d <= NS; d++) hist[d] = '0;
        for (int k = 0; k < NC; k++) rem[k] = 0;
        f_prev = 1'b0;
        idle_m = 1'b1;
    endtask

    initial begin
        logic          ovr;
        logic          f1;
        logic [NS-1:0] now_c1;
        logic [NS-1:0] prv_c1;
        logic [NC-1:0] exp_ch;
        logic          act;
        logic          gate;

        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc < 4) begin
                rst = 1'b0;
            end else begin
                rst           = ($urandom % 150) == 0;
                scan_mode     = ($urandom % 32) == 0;
                clk_override  = ($urandom % 24) == 0;
                ch_bus_clk_en = 1'($urandom % 2);
                free_busy     = ($urandom % 12) == 0;
                stage_store   = NS'($urandom);
                for (int i = 0; i < NS; i++)
                    stage_vld[i] = ($urandom % 6) == 0;
                for (int k = 0; k < NC; k++)
                    ch_req[k] = ($urandom % 10) == 0;
                if (($urandom % 25) == 0)
                    cfg_hold = (NC*HW)'($urandom);
            end
            #1;

            ovr    = clk_override | scan_mode;
            now_c1 = c1_at(0);
            prv_c1 = c1_at(1);
            exp_ch = '0;
            f1     = (|stage_vld) | (|prv_c1) | free_busy | ovr;
            for (int k = 0; k < NC; k++) begin
                act       = ch_req[k] | (rem[k] > 0);
                gate      = MASK[k] ? ch_bus_clk_en : 1'b1;
                exp_ch[k] = scan_mode | ((act | clk_override) & gate);
                f1        = f1 | act;
            end

            chk("c1_en", 32'(c1_en), 32'(now_c1 | {NS{ovr}}));
            chk("c2_en", 32'(c2_en), 32'(now_c1 | prv_c1 | {NS{ovr}}));
            chk("store_c1_en", 32'(store_c1_en),
                32'((now_c1 & stage_store) | {NS{ovr}}));
            chk("ch_en", 32'(ch_en), 32'(exp_ch));
            chk("free_c2_en", 32'(free_c2_en), 32'(f1 | f_prev));
            chk("all_idle", 32'(all_idle), 32'(idle_m));

            @(posedge clk);
            if (rst) begin
                model_reset();
            end else begin
                for (int d = NS; d >= 2; d--) hist[d] = hist[d-1];
                hist[1] = stage_vld;
                for (int k = 0; k < NC; k++) begin
                    gate = MASK[k] ? ch_bus_clk_en : 1'b1;
                    if (ch_req[k])
                        rem[k] = int'(cfg_hold[k*HW +: HW]);
                    else if (rem[k] > 0 && gate)
                        rem[k] = rem[k] - 1;
                end
                idle_m = !(f1 | f_prev);
                f_prev = f1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
